pc_sequencer: RTL

//  Parametrised next-generation program counter plus next-PC logic for the A0 core fetch stage.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/ras_stack.sv | 74 +++++++
 rtl/pc_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: next-PC source selector and the sequential PC step.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_J   = 2'd2,
        PC_JR  = 2'd3
    } pcsrc_t;

    localparam int unsigned PC_STEP = 4;

    // Clear the two byte-offset bits of a target so it is word aligned.
    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with top pointer and saturating occupancy count.
// A push when full overwrites the oldest entry; a pop when empty is a no-op.
// Simultaneous push and pop replaces the current top in place.
module ras_stack #(
    parameter int unsigned RAS_D = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] wdat,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PTR_W = $clog2(RAS_D);
    localparam int unsigned OCC_W = $clog2(RAS_D) + 1;
    localparam logic [OCC_W-1:0] DEPTH = OCC_W'(RAS_D);

    logic [PC_W-1:0]  mem [RAS_D];
    logic [PTR_W-1:0] tp;
    logic [PTR_W-1:0] tp_next;
    logic [OCC_W-1:0] cnt;
    logic [OCC_W-1:0] cnt_next;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;

    assign top   = mem[tp];
    assign empty = (cnt == '0);
    assign full  = (cnt == DEPTH);

    // Pointer, count and write-port selection for push, pop and push+pop.
    always_comb begin
        tp_next  = tp;
        cnt_next = cnt;
        wr_en    = 1'b0;
        wr_ptr   = tp;
        if (push && pop) begin
            // replace the top in place; occupancy is unchanged
            wr_en  = 1'b1;
            wr_ptr = tp;
        end else if (push) begin
            wr_en   = 1'b1;
            wr_ptr  = tp + PTR_W'(1);
            tp_next = tp + PTR_W'(1);
            if (!full) begin
                cnt_next = cnt + OCC_W'(1);
            end
        end else if (pop && !empty) begin
            tp_next  = tp - PTR_W'(1);
            cnt_next = cnt - OCC_W'(1);
        end
    end

    // Stack storage and pointer/count registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tp  <= '0;
            cnt <= '0;
            for (int unsigned i = 0; i < RAS_D; i++) begin
                mem[i] <= '0;
            end
        end else begin
            tp  <= tp_next;
            cnt <= cnt_next;
            if (wr_en) begin
                mem[wr_ptr] <= wdat;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with next-PC selection, a return-address
// stack predictor and saturating hit/miss statistics. The fetched PC is
// always the architecturally resolved target; the RAS only scores itself.
module pc_sequencer
    import cpu_types_pkg::*;
#(
    parameter int unsigned     PC_W    = 32,
    parameter logic [PC_W-1:0] PC_INIT = '0,
    parameter int unsigned     RAS_D   = 4,
    parameter int unsigned     CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             pc_en,
    input  pcsrc_t           pc_src,
    input  logic             br_taken,
    input  logic [15:0]      imm16,
    input  logic [25:0]      imm26,
    input  logic [PC_W-1:0]  jr_tgt,
    input  logic             is_jal,
    input  logic             is_ret,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             misalign,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [PC_W-1:0] J_MASK = PC_W'(28'hFFF_FFFF);

    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] j_tgt;
    logic [PC_W-1:0] jr_al;
    logic [PC_W-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_hit;
    logic            ras_miss;
    logic [63:0]     jr_wide;
    logic [63:0]     jr_wide_al;

    assign pc_plus4   = pc + PC_W'(PC_STEP);
    assign br_off     = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
    assign j_tgt      = (pc_plus4 & ~J_MASK) | PC_W'({imm26, 2'b00});
    assign jr_wide    = 64'(jr_tgt);
    assign jr_wide_al = word_align(jr_wide);
    assign jr_al      = jr_wide_al[PC_W-1:0];

    assign ras_push = pc_en & is_jal;
    assign ras_pop  = pc_en & is_ret;
    assign ras_hit  = ras_pop & ~ras_empty & (ras_top == jr_al);
    assign ras_miss = ras_pop & ~ras_hit;

    ras_stack #(
        .RAS_D (RAS_D),
        .PC_W  (PC_W)
    ) u_ras (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (ras_push),
        .pop   (ras_pop),
        .wdat  (pc_plus4),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    // Next-PC target mux; all arithmetic wraps modulo 2**PC_W.
    always_comb begin
        pc_next = pc_plus4;
        case (pc_src)
            PC_SEQ:  pc_next = pc_plus4;
            PC_BR:   pc_next = br_taken ? (pc_plus4 + br_off) : pc_plus4;
            PC_J:    pc_next = j_tgt;
            PC_JR:   pc_next = jr_al;
            default: pc_next = pc_plus4;
        endcase
    end

    // Program counter register, advancing only on enabled edges.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc <= PC_INIT;
        end else if (pc_en) begin
            pc <= pc_next;
        end
    end

    // One-cycle flag for a register target with nonzero byte offset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            misalign <= 1'b0;
        end else begin
            misalign <= pc_en & (pc_src == PC_JR) & (|jr_tgt[1:0]);
        end
    end

    // Saturating RAS prediction hit and miss counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (ras_hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (ras_miss && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule
